// File: rtl/instr_decode_stage.sv
// instr_decode_stage: RV32I decode with registered outputs, one-entry skid buffer and flush
module instr_decode_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rs1_en,
    output logic              out_rs2_en,
    output logic              out_rd_we,
    output logic [XLEN-1:0]   out_imm,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [6:0]        out_funct7,
    output logic              out_illegal
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              rs1_en;
        logic              rs2_en;
        logic              rd_we;
        logic [XLEN-1:0]   imm;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic              illegal;
    } bundle_t;

    bundle_t     dec, out_q, skid_q;
    logic        out_valid_q, skid_valid;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_load, is_opimm, is_sys, is_misc, is_store, is_branch, is_op;
    logic        is_u, is_i, known, op_ok, shift_ok, ill;

    assign op        = in_instr[6:0];
    assign f3        = in_instr[14:12];
    assign f7        = in_instr[31:25];
    assign is_lui    = op == 7'b0110111;
    assign is_auipc  = op == 7'b0010111;
    assign is_jal    = op == 7'b1101111;
    assign is_jalr   = op == 7'b1100111;
    assign is_load   = op == 7'b0000011;
    assign is_opimm  = op == 7'b0010011;
    assign is_sys    = op == 7'b1110011;
    assign is_misc   = op == 7'b0001111;
    assign is_store  = op == 7'b0100011;
    assign is_branch = op == 7'b1100011;
    assign is_op     = op == 7'b0110011;
    assign is_u      = is_lui | is_auipc;
    assign is_i      = is_jalr | is_load | is_opimm | is_sys | is_misc;
    assign known     = is_u | is_jal | is_i | is_store | is_branch | is_op;
    assign op_ok     = f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
    assign shift_ok  = f3 == 3'b001 ? f7 == 7'b0 : (f7 == 7'b0 || f7 == 7'b0100000);
    assign ill       = in_instr[1:0] != 2'b11 || !known
                     || (is_jalr && f3 != 3'b000)
                     || (is_branch && (f3 == 3'b010 || f3 == 3'b011))
                     || (is_load && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
                     || (is_store && f3 > 3'b010)
                     || (is_op && !op_ok)
                     || (is_opimm && (f3 == 3'b001 || f3 == 3'b101) && !shift_ok);

    // Combinational decode of the incoming word; illegal words keep only pc/opcode/funct fields
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = op;
        dec.funct3  = f3;
        dec.funct7  = f7;
        dec.illegal = ill;
        dec.rs1_en  = !ill && ((is_i && !is_misc) || is_store || is_branch || is_op);
        dec.rs2_en  = !ill && (is_store || is_branch || is_op);
        dec.rd_we   = !ill && (is_u || is_jal || is_i || is_op) && in_instr[11:7] != 5'd0;
        dec.rs1     = dec.rs1_en ? in_instr[19:15] : '0;
        dec.rs2     = dec.rs2_en ? in_instr[24:20] : '0;
        dec.rd      = dec.rd_we ? in_instr[11:7] : '0;
        dec.imm     = ill       ? '0
                    : is_u      ? {in_instr[31:12], 12'b0}
                    : is_jal    ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
                    : is_store  ? {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]}
                    : is_branch ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
                    : is_i      ? {{21{in_instr[31]}}, in_instr[30:20]}
                    : '0;
    end

    // Output register plus skid entry; skid drains ahead of new input, flush wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (skid_valid) begin
            if (out_ready) begin
                out_q      <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid_q || out_ready) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready    = !skid_valid;
    assign out_valid   = out_valid_q;
    assign out_pc      = out_q.pc;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rd      = out_q.rd;
    assign out_rs1_en  = out_q.rs1_en;
    assign out_rs2_en  = out_q.rs2_en;
    assign out_rd_we   = out_q.rd_we;
    assign out_imm     = out_q.imm;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_funct7  = out_q.funct7;
    assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed checks of decode, skid buffering, flush and async reset
module tb_instr_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_en, out_rs2_en, out_rd_we;
    logic [31:0] out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal;

    int tests = 0;
    int fails = 0;

    logic [31:0] vin [11];
    logic [50:0] vex [11];
    logic [50:0] got;
    logic [16:0] fld;

    instr_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_rd_we(out_rd_we),
        .out_imm(out_imm), .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    assign got = {out_rs1, out_rs2, out_rd, out_rs1_en, out_rs2_en, out_rd_we, out_imm, out_illegal};

    task automatic test_reset();
        #1;
        tests++;
        if ({out_valid, got, out_pc, out_opcode, out_funct3, out_funct7} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b bundle=%h pc=%h, expected all zero", out_valid, got, out_pc);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        vin[0]  = 32'hFFF00293; vex[0]  = {5'd0, 5'd0, 5'd5, 3'b101, 32'hFFFFFFFF, 1'b0};
        vin[1]  = 32'h00612423; vex[1]  = {5'd2, 5'd6, 5'd0, 3'b110, 32'h00000008, 1'b0};
        vin[2]  = 32'hFE208EE3; vex[2]  = {5'd1, 5'd2, 5'd0, 3'b110, 32'hFFFFFFFC, 1'b0};
        vin[3]  = 32'h00000000; vex[3]  = {5'd0, 5'd0, 5'd0, 3'b000, 32'h00000000, 1'b1};
        vin[4]  = 32'h123451B7; vex[4]  = {5'd0, 5'd0, 5'd3, 3'b001, 32'h12345000, 1'b0};
        vin[5]  = 32'h008000EF; vex[5]  = {5'd0, 5'd0, 5'd1, 3'b001, 32'h00000008, 1'b0};
        vin[6]  = 32'h409403B3; vex[6]  = {5'd8, 5'd9, 5'd7, 3'b111, 32'h00000000, 1'b0};
        vin[7]  = 32'h409413B3; vex[7]  = {5'd0, 5'd0, 5'd0, 3'b000, 32'h00000000, 1'b1};
        vin[8]  = 32'h00100013; vex[8]  = {5'd0, 5'd0, 5'd0, 3'b100, 32'h00000001, 1'b0};
        vin[9]  = 32'h000110E7; vex[9]  = {5'd0, 5'd0, 5'd0, 3'b000, 32'h00000000, 1'b1};
        vin[10] = 32'h00013083; vex[10] = {5'd0, 5'd0, 5'd0, 3'b000, 32'h00000000, 1'b1};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_instr  = vin[i];
            in_pc     = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0;
            fld = {vin[i][6:0], vin[i][14:12], vin[i][31:25]};
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(i * 4)) begin
                fails++;
                $display("FAIL decode_valid_pc[%0d]: got valid=%b pc=%h expected 1 pc=%h", i, out_valid, out_pc, 32'h1000 + 32'(i * 4));
            end
            tests++;
            if (got !== vex[i]) begin
                fails++;
                $display("FAIL decode_bundle[%0d] instr=%h: got %h expected %h", i, vin[i], got, vex[i]);
            end
            tests++;
            if ({out_opcode, out_funct3, out_funct7} !== fld) begin
                fails++;
                $display("FAIL decode_fields[%0d]: got %h expected %h", i, {out_opcode, out_funct3, out_funct7}, fld);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_instr = {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011};
            in_pc    = 32'h200 + 32'(i * 4);
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(i * 4) || out_rd !== 5'(i) || out_imm !== 32'(i) || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got valid=%b pc=%h rd=%0d imm=%h rdy=%b expected 1 %h %0d %h 1",
                         i, out_valid, out_pc, out_rd, out_imm, in_ready, 32'h200 + 32'(i * 4), i, i);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL back_to_back_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h100;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h100) begin
            fails++;
            $display("FAIL bp_accept_a: got rdy=%b valid=%b pc=%h expected 1 1 00000100", in_ready, out_valid, out_pc);
        end
        in_instr = 32'h00200113;
        in_pc    = 32'h104;
        @(negedge clk);
        in_instr = 32'h00300193;
        in_pc    = 32'h108;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h100 || out_rd !== 5'd1 || out_imm !== 32'd1) begin
                fails++;
                $display("FAIL bp_stall_hold[%0d]: got rdy=%b valid=%b pc=%h rd=%0d imm=%h expected 0 1 00000100 1 1",
                         k, in_ready, out_valid, out_pc, out_rd, out_imm);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_drain_b: got valid=%b pc=%h rd=%0d rdy=%b expected 1 00000104 2 1", out_valid, out_pc, out_rd, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h108 || out_rd !== 5'd3 || out_imm !== 32'd3) begin
            fails++;
            $display("FAIL bp_drain_c: got valid=%b pc=%h rd=%0d imm=%h expected 1 00000108 3 3", out_valid, out_pc, out_rd, out_imm);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_empty: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h300;
        @(negedge clk);
        in_instr = 32'h00200113;
        in_pc    = 32'h304;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL flush_setup: got rdy=%b valid=%b expected 0 1", in_ready, out_valid);
        end
        flush    = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 32'h308;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_clear: got valid=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_no_replay[%0d]: got valid=%b pc=%h expected valid 0", k, out_valid, out_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00612423;
        in_pc     = 32'h400;
        @(negedge clk);
        in_instr = 32'hFE208EE3;
        in_pc    = 32'h404;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, got, out_pc, out_opcode, out_funct3, out_funct7} !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got valid=%b bundle=%h pc=%h rdy=%b expected zeros and rdy 1", out_valid, got, out_pc, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00293;
        in_pc     = 32'h500;
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h500 || got !== {5'd0, 5'd0, 5'd5, 3'b101, 32'hFFFFFFFF, 1'b0}) begin
            fails++;
            $display("FAIL post_reset_decode: got valid=%b pc=%h bundle=%h expected 1 00000500 %h",
                     out_valid, out_pc, got, {5'd0, 5'd0, 5'd5, 3'b101, 32'hFFFFFFFF, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- RV32I decode stage directly upstream of the register-select block.
- Accepts fetched instruction words with a valid/ready handshake and extracts the rs1/rs2/rd indices that feed the register-select block.
- Also produces the sign-extended immediate, control fields, register enables and an illegal-instruction flag.
- Outputs are registered. A one-entry skid buffer allows full throughput under backpressure. A flush input supports branch redirect.

Parameters:
- XLEN, 32, data/PC/immediate width; only 32 is supported.
- REG_AW, 5, register index width.

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous; discards all held instructions.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept an instruction.
- in_instr  input  32  instruction word.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_pc  output  XLEN  PC of the bundle.
- out_rs1, out_rs2, out_rd  output  REG_AW each  register indices.
- out_rs1_en, out_rs2_en  output  1 each  source register is read.
- out_rd_we  output  1  destination is written.
- out_imm  output  XLEN  sign-extended immediate.
- out_opcode  output  7  opcode field.
- out_funct3  output  3  funct3 field.
- out_funct7  output  7  funct7 field.
- out_illegal  output  1  instruction is illegal.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, skid buffer empty, in_ready=1.
  - Every other output is 0.
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - out_* must stay stable while out_valid=1 and out_ready=0.
- Latency:
  - An accepted instruction appears on out_* on the next cycle.
  - Sustained throughput is 1 instruction per cycle.
- Skid buffer:
  - in_ready = !skid_valid, registered (no combinational path from out_ready).
  - If the output register is full and not draining, a newly accepted instruction goes into the skid buffer.
  - When the output drains, the skid contents move to the output before any new input, so program order is preserved.
- Decode is combinational on the input side and registered into the output/skid entries:
  - Formats: U (LUI 0110111, AUIPC 0010111), J (JAL 1101111), I (JALR 1100111, LOAD 0000011, OP-IMM 0010011, SYSTEM 1110011, MISC-MEM 0001111), S (STORE 0100011), B (BRANCH 1100011), R (OP 0110011).
  - Immediates follow the RV32I bit placement and are sign-extended from instr[31]. U-type is instr[31:12]<<12. R-type gives imm=0.
  - rs1_en=1 for I/S/B/R formats, except LUI/AUIPC/JAL and MISC-MEM.
  - rs2_en=1 for S/B/R formats only.
  - rd_we=1 for U/J/I/R formats, but forced to 0 when rd==0.
  - An unused index field is driven as 0, so register select reads x0.
- Illegal detection (out_illegal=1):
  - instr[1:0] != 2'b11, or an unlisted opcode.
  - JALR with funct3 != 000.
  - BRANCH with funct3 of 010 or 011.
  - LOAD with funct3 of 011, 110 or 111.
  - STORE with funct3 > 010.
  - OP with funct7 other than 0000000, or other than 0100000 for funct3 000/101.
  - OP-IMM shift (funct3 001/101) with illegal funct7.
  - When illegal: all enables are 0, indices and imm are 0, and opcode/funct/pc pass through.
- Flush:
  - On the next edge, out_valid=0 and the skid buffer is empty; in_ready=1 the following cycle.
  - An in_valid handshake in the flush cycle is discarded.
- Simultaneous events:
  - Flush has priority over accept and drain.
  - Drain and accept in the same cycle with the skid buffer empty: the new bundle replaces the output register.
- Reset mid-operation: immediately returns to the reset state; in-flight instructions are lost.

Test Plan:
- addi x5,x0,-1 (0xFFF00293), out_ready=1 -> next cycle out_rd=5, out_rd_we=1, out_rs1=0, out_rs1_en=1, out_rs2_en=0, out_imm=0xFFFFFFFF, out_illegal=0.
- sw x6,8(x2) (0x00612423) -> out_rs1=2, out_rs2=6, both enables=1, out_rd_we=0, out_rd=0, out_imm=0x00000008.
- beq x1,x2,-4 (0xFE208EE3) -> out_imm=0xFFFFFFFC, out_rs1=1, out_rs2=2, out_rd_we=0. Then 0x00000000 -> out_illegal=1 with all enables 0.
- Backpressure: out_ready=0, drive three back-to-back instructions A, B, C.
  - A and B are accepted and C is stalled (in_ready=0 from the cycle after B).
  - Raise out_ready: the outputs are A, B, C on consecutive cycles with out_* stable while stalled.
- Flush with the output and skid buffer both full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of the three instructions appears.
- Assert rst_n=0 asynchronously mid-stream -> out_valid=0 and all outputs 0 without a clock edge. After release, the first accepted instruction decodes correctly after 1 cycle.
